// File: rtl/clk_reset_seq.sv
// Power-on reset sequencer: holds resetn low until pll_locked has been stable, re-arms on lock loss or button.
// Optional macro CLK_RESET_SEQ_BTN_DEBOUNCE_EN adds a debounce counter in front of the button event.
module clk_reset_seq #(
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       btn,
    output logic       resetn,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } fsm_t;

    fsm_t             fsm;
    logic [CNT_W-1:0] stable_cnt;
    logic             locked_m;
    logic             locked_s;
    logic             btn_m;
    logic             btn_s;
    logic             btn_event;

    // Two-flop synchronizers for the asynchronous inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            locked_m <= pll_locked;
            locked_s <= locked_m;
            btn_m    <= btn;
            btn_s    <= btn_m;
        end
    end

`ifdef CLK_RESET_SEQ_BTN_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

    logic [DEB_W-1:0] deb_cnt;

    // Counter parks at DEB_MAX so a held button yields a single event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
        end else if (!btn_s) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign btn_event = btn_s && (deb_cnt == DEB_LAST);
`else
    logic btn_s_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s_prev <= 1'b0;
        end else begin
            btn_s_prev <= btn_s;
        end
    end

    assign btn_event = btn_s & ~btn_s_prev;

    // Debounce length has no role without the debounce counter
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    end
`endif

    // Sequencer FSM; lock loss in RUN takes priority over a button event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm             <= WAIT_LOCK;
            stable_cnt      <= '0;
            resetn          <= 1'b0;
            lock_lost       <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            case (fsm)
                WAIT_LOCK: begin
                    stable_cnt <= '0;
                    resetn     <= 1'b0;
                    if (locked_s) begin
                        fsm <= STABLE;
                    end
                end
                STABLE: begin
                    resetn <= 1'b0;
                    if (!locked_s) begin
                        fsm        <= WAIT_LOCK;
                        stable_cnt <= '0;
                    end else if (stable_cnt == CNT_LAST) begin
                        fsm        <= RUN;
                        stable_cnt <= '0;
                        resetn     <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        fsm       <= WAIT_LOCK;
                        resetn    <= 1'b0;
                        lock_lost <= 1'b1;
                        if (lock_loss_count != 8'd255) begin
                            lock_loss_count <= lock_loss_count + 8'd1;
                        end
                    end else if (btn_event) begin
                        fsm        <= STABLE;
                        stable_cnt <= '0;
                        resetn     <= 1'b0;
                    end
                end
                default: begin
                    fsm        <= WAIT_LOCK;
                    stable_cnt <= '0;
                    resetn     <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Scoreboard bench for clk_reset_seq: stimulus queues expected resetn edges, a monitor checks them.
// Builds with or without CLK_RESET_SEQ_BTN_DEBOUNCE_EN to match the design under test.
module tb_clk_reset_seq;
    localparam int unsigned N = 16;
    localparam int unsigned D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       btn;
    logic       resetn;
    logic       lock_lost;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    clk_reset_seq #(
        .STABLE_CYCLES  (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .btn            (btn),
        .resetn         (resetn),
        .lock_lost      (lock_lost),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       rn;
        logic [1:0] st;
        logic       lost;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic       exp_lost = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic push(input int c, input logic rn, input logic [1:0] st);
        exp_t e;
        e.cyc  = c;
        e.rn   = rn;
        e.st   = st;
        e.lost = exp_lost;
        e.cnt  = exp_cnt;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected resetn events still pending after %0d cycles", name, q.size(), limit);
            q.delete();
        end
    endtask

    // Monitor: every resetn transition must match the head of the queue
    initial begin
        logic prev;
        exp_t e;
        @(negedge clk);
        prev = resetn;
        forever begin
            @(negedge clk);
            if (resetn !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: resetn=%b state=%0d at cycle %0d with nothing expected",
                             resetn, state, cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || resetn !== e.rn || state !== e.st ||
                        lock_lost !== e.lost || lock_loss_count !== e.cnt) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d resetn=%b state=%0d lost=%b cnt=%0d, expected cyc=%0d resetn=%b state=%0d lost=%b cnt=%0d",
                                 cyc, resetn, state, lock_lost, lock_loss_count,
                                 e.cyc, e.rn, e.st, e.lost, e.cnt);
                    end
                end
                prev = resetn;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        reset      = 1'b1;
        pll_locked = 1'b0;
        btn        = 1'b0;
        #1;
        chk("rst_resetn", resetn, 0);
        chk("rst_state", state, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_count", lock_loss_count, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Lock acquisition: release N+2 edges after the sampling edge
        pll_locked = 1'b1;
        t0 = cyc;
        push(t0 + N + 3, 1'b1, 2'd2);
        repeat (8) @(negedge clk);
        chk("acq_state_stable", state, 1);
        chk("acq_resetn_low", resetn, 0);
        wait_drain("lock_acquire", 40);
        chk("acq_state_run", state, 2);

        // Single-cycle lock loss in RUN
        @(negedge clk);
        pll_locked = 1'b0;
        t0 = cyc;
        exp_lost = 1'b1;
        exp_cnt  = 8'd1;
        push(t0 + 3, 1'b0, 2'd0);
        push(t0 + 20, 1'b1, 2'd2);
        @(negedge clk);
        pll_locked = 1'b1;
        wait_drain("lock_loss", 40);

`ifdef CLK_RESET_SEQ_BTN_DEBOUNCE_EN
        // Short press is filtered out
        @(negedge clk);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("short_press_state", state, 2);
        chk("short_press_resetn", resetn, 1);

        // 20-cycle press: one event, resetn low for N cycles
        @(negedge clk);
        btn = 1'b1;
        t0 = cyc;
        push(t0 + 10, 1'b0, 2'd1);
        push(t0 + 10 + N, 1'b1, 2'd2);
        repeat (20) @(negedge clk);
        btn = 1'b0;
        wait_drain("press_20", 60);

        // Long press still gives a single event
        @(negedge clk);
        btn = 1'b1;
        t0 = cyc;
        push(t0 + 10, 1'b0, 2'd1);
        push(t0 + 10 + N, 1'b1, 2'd2);
        repeat (40) @(negedge clk);
        btn = 1'b0;
        wait_drain("press_40", 60);
        repeat (10) @(negedge clk);
        chk("press_40_state", state, 2);

        // Lock loss and debounced event on the same edge: loss wins
        @(negedge clk);
        btn = 1'b1;
        t0 = cyc;
        exp_cnt = 8'd2;
        push(t0 + 10, 1'b0, 2'd0);
        push(t0 + 27, 1'b1, 2'd2);
        repeat (7) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        btn = 1'b0;
        wait_drain("loss_and_btn", 60);
`else
        // One-cycle button pulse in RUN
        @(negedge clk);
        btn = 1'b1;
        t0 = cyc;
        push(t0 + 3, 1'b0, 2'd1);
        push(t0 + 3 + N, 1'b1, 2'd2);
        @(negedge clk);
        btn = 1'b0;
        wait_drain("btn_pulse", 40);

        // Lock loss and button edge on the same edge: loss wins
        @(negedge clk);
        btn = 1'b1;
        pll_locked = 1'b0;
        t0 = cyc;
        exp_cnt = 8'd2;
        push(t0 + 3, 1'b0, 2'd0);
        push(t0 + 20, 1'b1, 2'd2);
        @(negedge clk);
        btn = 1'b0;
        pll_locked = 1'b1;
        wait_drain("loss_and_btn", 40);
`endif

        // Asynchronous reset in RUN clears everything before the next edge
        @(negedge clk);
        chk("pre_rst_lost", lock_lost, 1);
        chk("pre_rst_count", lock_loss_count, 2);
        t0 = cyc;
        exp_lost = 1'b0;
        exp_cnt  = 8'd0;
        push(t0 + 1, 1'b0, 2'd0);
        #2 reset = 1'b1;
        #1;
        chk("run_rst_resetn", resetn, 0);
        chk("run_rst_state", state, 0);
        chk("run_rst_lost", lock_lost, 0);
        chk("run_rst_count", lock_loss_count, 0);
        pll_locked = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Lock glitch at STABLE count 10 restarts the full count
        pll_locked = 1'b1;
        t0 = cyc;
        push(t0 + 31, 1'b1, 2'd2);
        repeat (11) @(negedge clk);
        chk("glitch_pre_state", state, 1);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_state", state, 0);
        wait_drain("glitch", 40);
        chk("glitch_count", lock_loss_count, 0);

        // Asynchronous reset in STABLE
        @(negedge clk);
        t0 = cyc;
        push(t0 + 1, 1'b0, 2'd0);
        #2 reset = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (8) @(negedge clk);
        chk("stable_pre_rst_state", state, 1);
        #2 reset = 1'b1;
        #1;
        chk("stable_rst_state", state, 0);
        chk("stable_rst_resetn", resetn, 0);
        @(negedge clk);
        reset = 1'b0;
        t1 = cyc;
        push(t1 + N + 3, 1'b1, 2'd2);
        wait_drain("stable_rst_relock", 40);

        // 300 lock losses: count saturates at 255
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pll_locked = 1'b0;
            t0 = cyc;
            exp_lost = 1'b1;
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
            push(t0 + 3, 1'b0, 2'd0);
            push(t0 + 20, 1'b1, 2'd2);
            @(negedge clk);
            pll_locked = 1'b1;
            wait_drain("loss_loop", 40);
        end
        chk("sat_count", lock_loss_count, 255);
        chk("sat_lost", lock_lost, 1);
        chk("sat_state", state, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_reset_seq.md
CLK_RESET_SEQ -- requirements
Module: clk_reset_seq

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: clk cycles pll_locked must stay high before resetn is released; legal range 1..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000: consecutive cycles btn must be high to count as a press; legal range 1..2^20-1.
REQ-003 clk  in  1  system clock, from the PLL/BUFG output.
REQ-004 reset  in  1  asynchronous, active-high; forces all state at once.
REQ-005 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-006 btn  in  1  user reset button, asynchronous, active-high.
REQ-007 resetn  out  1  active-low synchronous reset for the design; driven directly from a flop.
REQ-008 lock_lost  out  1  sticky flag, set on the first loss of lock while in RUN.
REQ-009 lock_loss_count  out  8  count of lock losses while in RUN; saturates at 255.
REQ-010 state  out  2  current FSM state, for debug.

Function
REQ-011 pll_locked and btn shall each pass through a 2-flop synchronizer, giving locked_s and btn_s.
REQ-012 FSM states: WAIT_LOCK=2'd0, STABLE=2'd1, RUN=2'd2; encoding 2'd3 shall go to WAIT_LOCK on the next edge.
REQ-013 WAIT_LOCK: stability counter is 0 and resetn is 0; locked_s=1 -> STABLE.
REQ-014 STABLE: counter increments each cycle.
  - locked_s=0 -> WAIT_LOCK, counter cleared.
  - counter==STABLE_CYCLES-1 -> RUN, and resetn<=1 on the same edge.
REQ-015 RUN, locked_s=0 -> WAIT_LOCK on the same edge.
  - resetn<=0, lock_lost<=1.
  - lock_loss_count increments unless already 255.
REQ-016 RUN, btn_event=1 -> STABLE with counter 0 and resetn<=0; resetn is then low for exactly STABLE_CYCLES cycles if lock holds.
REQ-017 If locked_s=0 and btn_event=1 in the same RUN cycle, lock loss wins (REQ-015); btn_event is dropped.
REQ-018 btn_event outside RUN shall be ignored; debounce tracking continues in every state.
REQ-019 Latency: resetn rises exactly STABLE_CYCLES+2 edges after the first edge that samples pll_locked high, provided lock stays high.
REQ-020 A pll_locked glitch of 1 cycle or more seen on locked_s during STABLE restarts the full STABLE_CYCLES count.
REQ-021 resetn shall never pulse high for less than one full RUN residency and shall have no combinational path from any input.

Reset
REQ-022 reset=1 shall asynchronously force the following, regardless of current state:
  - state=WAIT_LOCK, all counters 0, synchronizer flops 0;
  - resetn=0, lock_lost=0, lock_loss_count=0.
REQ-023 Deassertion of reset is used as-is (no internal resynchronization); FSM starts in WAIT_LOCK on the first edge after release.

Configuration
REQ-024 Macro CLK_RESET_SEQ_BTN_DEBOUNCE_EN defined: a counter (width clog2(DEBOUNCE_CYCLES+1)) counts consecutive btn_s=1 cycles and clears on btn_s=0.
  - btn_event is a single-cycle pulse when the count reaches DEBOUNCE_CYCLES.
  - One event per press; btn must return low before the next event.
REQ-025 Macro CLK_RESET_SEQ_BTN_DEBOUNCE_EN undefined: btn_event = btn_s & ~btn_s_prev (rising edge of btn_s); DEBOUNCE_CYCLES is ignored and no debounce counter is built.

Verification
REQ-026 STABLE_CYCLES=16; pll_locked rises before edge 10 -> resetn=1 after edge 28; state=2'd2.
REQ-027 STABLE_CYCLES=16; pll_locked low for 1 cycle at STABLE count 10 -> state returns to 0, then resetn rises 18 edges after lock returns; lock_loss_count stays 0.
REQ-028 In RUN, drop pll_locked 300 times -> lock_lost=1, lock_loss_count=255 (saturated), resetn=0 on each loss 2 edges after pll_locked falls.
REQ-029 BTN_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=8.
  - btn high for 5 cycles -> no effect.
  - btn high for 20 cycles -> resetn low for exactly 16 cycles, one event only.
REQ-030 Macro undefined -> 1-cycle btn pulse in RUN gives resetn low for 16 cycles. Same-cycle lock loss plus btn -> state=0 and count +1.
REQ-031 Assert reset mid-STABLE and mid-RUN -> all outputs return to reset values immediately, without waiting for a clk edge.
